loadip_stream_reader: RTL
=========================

Name: loadip_stream_reader

Overview:
- Drains the read side of the ping-pong load buffer one block at a time.
- Converts each block into a valid/ready stream with a last-beat marker for downstream compute and DMA consumers.
- Owns the buffer's read handshake (activate, strobe, release) and absorbs downstream backpressure in an internal 2-entry skid buffer.
- Sits between the ping-pong buffer read port and any stream sink.

Parameters:
- DATA_WIDTH, 16, word width; must match the buffer.
- CNT_WIDTH, 16, width of the block word count from the buffer.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_rd_ready  in  1  buffer has a filled block available.
- o_rd_activate  out  1  reader owns the current block; hold high for the entire block.
- i_rd_cnt  in  CNT_WIDTH  word count of the offered block; valid while i_rd_ready is high.
- i_rdata  in  DATA_WIDTH  current buffer word, first-word-fall-through: valid while activated; o_rstrobe advances to the next word.
- o_rstrobe  out  1  pop one word.
- o_tvalid  out  1  stream beat valid.
- i_tready  in  1  sink accepts the beat.
- o_tdata  out  DATA_WIDTH  beat data.
- o_tlast  out  1  final beat of the block.
- o_busy  out  1  state is not IDLE.
- o_blk_done  out  1  one-cycle pulse when a block is released.

Behaviour:
- Reset: all outputs 0; state IDLE; word counter 0; skid buffer empty.
- Assertion of i_rst_n low mid-block aborts immediately. Partial data is discarded; the buffer's own reset recovers it.
- States:
  - IDLE -> ACTIVATE when i_rd_ready=1. Latch i_rd_cnt into rem_cnt and assert o_rd_activate the next cycle.
  - ACTIVATE (1 cycle): wait for data to settle; o_rstrobe=0. If rem_cnt==0, go to RELEASE, producing no beats. Otherwise go to STREAM.
  - STREAM: each cycle the skid buffer has a free slot and rem_cnt>0:
    - assert o_rstrobe;
    - push i_rdata with last=(rem_cnt==1);
    - decrement rem_cnt.
    - When rem_cnt reaches 0, go to DRAIN.
  - DRAIN: o_rstrobe=0. Wait until the skid buffer is empty, i.e. the beat with last=1 has been accepted. Then go to RELEASE.
  - RELEASE (1 cycle): deassert o_rd_activate; pulse o_blk_done. Go to IDLE.
  - IDLE ignores i_rd_ready in the cycle after RELEASE, so the buffer can drop ready. Minimum gap between blocks is 2 cycles.
- Strobe rule: o_rstrobe is never asserted when o_rd_activate=0, rem_cnt==0, or the skid buffer is full. No more than i_rd_cnt strobes are issued per block.
- Skid buffer: 2 entries, each holding data+last.
  - o_tvalid = buffer not empty; o_tdata/o_tlast = head entry.
  - Beat accepted when o_tvalid & i_tready.
  - Simultaneous push and pop in the same cycle is legal at any occupancy below full. At full, push is suppressed that cycle.
- Throughput: 1 beat/cycle sustained while i_tready=1.
- Latency: first beat appears on o_tvalid 3 cycles after i_rd_ready rises (IDLE->ACTIVATE->STREAM push->visible).
- o_tvalid, once high, stays high with o_tdata stable until accepted.
- i_rd_cnt is sampled only on IDLE->ACTIVATE; later changes are ignored.
- rem_cnt is CNT_WIDTH wide and never underflows.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE=0, ACTIVATE=1, STREAM=2, DRAIN=3, RELEASE=4 (3-bit);
  - SKID_DEPTH=2.
- One sub-module: loadip_skid_fifo, a 2-entry data+last FIFO with push/pop/full/empty.
- The top level holds the FSM and rem_cnt.

Test Plan:
- Block cnt=4, data 0xA0..0xA3, i_tready=1:
  - 4 beats in consecutive cycles; o_tlast only on 0xA3;
  - exactly 4 strobes;
  - o_blk_done pulses once;
  - o_rd_activate drops 2 cycles after the last beat accepts.
- Same block, i_tready toggling 1,0,0,1,...:
  - no data loss or duplication;
  - o_rstrobe stalls when the skid buffer is full;
  - o_tdata stable while o_tvalid & !i_tready.
- cnt=0 block:
  - activate high for 2 cycles (ACTIVATE, RELEASE);
  - zero strobes; o_tvalid never asserted;
  - o_blk_done pulses.
- Back-to-back blocks cnt=3 then cnt=2 with i_rd_ready held:
  - 5 beats total; o_tlast on beats 3 and 5;
  - activate deasserted at least 1 cycle between blocks.
- cnt=0xFFFF:
  - 65535 beats; rem_cnt ends at 0;
  - no extra strobe; o_tlast on the final beat only.
- Reset asserted mid-STREAM (after 2 of 8 beats):
  - all outputs 0 asynchronously;
  - after release, a new cnt=2 block streams correctly.

Source files
------------

// File: rtl/loadip_stream_reader_pkg.sv
// Shared definitions for the load-buffer stream reader: FSM encoding and skid depth.
package loadip_stream_reader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACTIVATE = 3'd1,
    STREAM   = 3'd2,
    DRAIN    = 3'd3,
    RELEASE  = 3'd4
  } reader_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/loadip_skid_fifo.sv
// Two-entry data+last FIFO that absorbs downstream backpressure for the stream reader.
module loadip_skid_fifo
  import loadip_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_push_last,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [DATA_WIDTH-1:0] data_q [SKID_DEPTH];
  logic                  last_q [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  do_push;
  logic                  do_pop;

  assign o_full  = (count == 2'(SKID_DEPTH));
  assign o_empty = (count == 2'd0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = data_q[rd_ptr];
  assign o_last  = last_q[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr] <= i_push_data;
        last_q[wr_ptr] <= i_push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/loadip_stream_reader.sv
// Drains one ping-pong buffer block per handshake and presents it as a valid/ready stream with tlast.
module loadip_stream_reader
  import loadip_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_ready,
  output logic                  o_rd_activate,
  input  logic [CNT_WIDTH-1:0]  i_rd_cnt,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_rstrobe,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tlast,
  output logic                  o_busy,
  output logic                  o_blk_done
);

  reader_state_t        state;
  reader_state_t        state_nxt;
  logic [CNT_WIDTH-1:0] rem_cnt;
  logic [CNT_WIDTH-1:0] rem_cnt_nxt;
  logic                 cooldown;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_single;

  assign fifo_pop      = o_tvalid && i_tready;
  assign fifo_single   = !fifo_empty && !fifo_full;
  assign o_tvalid      = !fifo_empty;
  assign o_rd_activate = (state != IDLE);
  assign o_busy        = (state != IDLE);
  assign o_blk_done    = (state == RELEASE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      rem_cnt  <= '0;
      cooldown <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem_cnt  <= rem_cnt_nxt;
      cooldown <= (state == RELEASE);
    end
  end

  // DRAIN may leave as soon as the final beat is being accepted, so activate drops two cycles after it.
  always_comb begin
    state_nxt   = state;
    rem_cnt_nxt = rem_cnt;
    o_rstrobe   = 1'b0;
    fifo_push   = 1'b0;
    case (state)
      IDLE: begin
        if (i_rd_ready && !cooldown) begin
          state_nxt   = ACTIVATE;
          rem_cnt_nxt = i_rd_cnt;
        end
      end
      ACTIVATE: begin
        state_nxt = (rem_cnt == '0) ? RELEASE : STREAM;
      end
      STREAM: begin
        if (rem_cnt == '0) begin
          state_nxt = DRAIN;
        end else if (!fifo_full) begin
          o_rstrobe   = 1'b1;
          fifo_push   = 1'b1;
          rem_cnt_nxt = rem_cnt - 1'b1;
          if (rem_cnt == CNT_WIDTH'(1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty || (fifo_single && fifo_pop)) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  loadip_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (fifo_push),
    .i_push_data(i_rdata),
    .i_push_last(rem_cnt == CNT_WIDTH'(1)),
    .i_pop      (fifo_pop),
    .o_data     (o_tdata),
    .o_last     (o_tlast),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty)
  );

endmodule
